// File: rtl/read_axi_buffer_pkg.sv
// Shared types and AXI constants for the read_axi_buffer line/word fetch engine.
package read_axi_buffer_pkg;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned ADDR_W = 32;
  localparam int unsigned LEN_W  = 8;
  localparam int unsigned SIZE_W = 3;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_WAIT_ADDR = 2'd1,
    ST_WAIT_DATA = 2'd2,
    ST_DONE      = 2'd3
  } state_e;

  // Burst length codes (AXI arlen is beats-1).
  localparam logic [LEN_W-1:0] ARLEN_SINGLE = LEN_W'(0);

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  typedef struct packed {
    logic              uncached;
    logic [SIZE_W-1:0] size;
    logic [ADDR_W-1:0] addr;
  } rd_req_t;

  function automatic logic resp_is_err(input logic [1:0] resp);
    case (resp)
      RESP_SLVERR, RESP_DECERR: return 1'b1;
      RESP_OKAY, RESP_EXOKAY:   return 1'b0;
      default:                  return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/read_axi_buffer.sv
// Issues one AXI4 read per request (single beat or full line refill) and buffers the result.
// Optional macro READ_AXI_RRESP_CHECK_EN: flags SLVERR/DECERR beats in resp_err.
module read_axi_buffer
  import read_axi_buffer_pkg::*;
#(
  parameter int unsigned LINE_SIZE = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   en,
  input  logic                   uncached,
  input  logic [ADDR_W-1:0]      addr,
  input  logic [SIZE_W-1:0]      size,
  output logic                   empty,
  output logic                   done,
  output logic [DATA_W-1:0]      rd_word,
  output logic [LINE_SIZE*8-1:0] rd_line,
  output logic                   resp_err,
  output logic [ADDR_W-1:0]      axi_araddr,
  output logic [LEN_W-1:0]       axi_arlen,
  output logic [SIZE_W-1:0]      axi_arsize,
  output logic                   axi_arvalid,
  input  logic                   axi_arready,
  input  logic [DATA_W-1:0]      axi_rdata,
  input  logic [1:0]             axi_rresp,
  input  logic                   axi_rlast,
  input  logic                   axi_rvalid,
  output logic                   axi_rready
);

  localparam int unsigned BEATS = LINE_SIZE / 4;
  localparam int unsigned CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [CNT_W-1:0] LAST_SLOT  = CNT_W'(BEATS - 1);
  localparam logic [LEN_W-1:0] LINE_ARLEN = LEN_W'(BEATS - 1);

  state_e           state_q, state_d;
  rd_req_t          req_q;
  logic [CNT_W-1:0] cnt_q;
  logic             full_q;
  logic             accept;
  logic             ar_fire;
  logic             r_fire;

  assign accept  = (state_q == ST_IDLE) && en;
  assign ar_fire = axi_arvalid && axi_arready;
  assign r_fire  = axi_rvalid && axi_rready;

  always_ff @(posedge clk or posedge rst) begin : state_reg
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin : next_state
    state_d = state_q;
    case (state_q)
      ST_IDLE:      if (en) state_d = ST_WAIT_ADDR;
      ST_WAIT_ADDR: if (ar_fire) state_d = ST_WAIT_DATA;
      ST_WAIT_DATA: if (r_fire && axi_rlast) state_d = ST_DONE;
      ST_DONE:      state_d = ST_IDLE;
      default:      state_d = ST_IDLE;
    endcase
  end

  always_comb begin : outputs
    empty       = 1'b0;
    done        = 1'b0;
    axi_arvalid = 1'b0;
    axi_araddr  = '0;
    axi_arlen   = '0;
    axi_arsize  = '0;
    axi_rready  = 1'b0;
    case (state_q)
      ST_IDLE: empty = 1'b1;
      ST_WAIT_ADDR: begin
        axi_arvalid = 1'b1;
        axi_araddr  = req_q.addr;
        axi_arlen   = req_q.uncached ? ARLEN_SINGLE : LINE_ARLEN;
        axi_arsize  = req_q.size;
      end
      ST_WAIT_DATA: axi_rready = 1'b1;
      ST_DONE:      done = 1'b1;
      default: ;
    endcase
  end

  // Beat slot counter parks on the last slot; full_q marks that slot written so overrun beats drop.
  always_ff @(posedge clk or posedge rst) begin : datapath
    if (rst) begin
      req_q   <= '0;
      cnt_q   <= '0;
      full_q  <= 1'b0;
      rd_word <= '0;
      rd_line <= '0;
    end else if (accept) begin
      req_q   <= '{uncached: uncached, size: size, addr: addr};
      cnt_q   <= '0;
      full_q  <= 1'b0;
      rd_word <= '0;
      rd_line <= '0;
    end else if (r_fire && !full_q) begin
      rd_line[DATA_W*cnt_q +: DATA_W] <= axi_rdata;
      if (cnt_q == '0) rd_word <= axi_rdata;
      if (cnt_q == LAST_SLOT) full_q <= 1'b1;
      else                    cnt_q  <= cnt_q + CNT_W'(1);
    end
  end

`ifdef READ_AXI_RRESP_CHECK_EN
  always_ff @(posedge clk or posedge rst) begin : err_flag
    if (rst)                                    resp_err <= 1'b0;
    else if (accept)                            resp_err <= 1'b0;
    else if (r_fire && resp_is_err(axi_rresp))  resp_err <= 1'b1;
  end
`else
  logic unused_rresp;
  assign unused_rresp = ^axi_rresp;
  assign resp_err     = 1'b0;
`endif

endmodule

// File: tb/tb_read_axi_buffer.sv
// Directed bench for read_axi_buffer with a transaction-level reference model checked every cycle.
module tb_read_axi_buffer;

  localparam int unsigned LINE_SIZE = 16;
  localparam int unsigned BEATS     = LINE_SIZE / 4;
`ifdef READ_AXI_RRESP_CHECK_EN
  localparam bit ERR_ON = 1'b1;
`else
  localparam bit ERR_ON = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         en, uncached;
  logic [31:0]  addr;
  logic [2:0]   size;
  logic         empty, done, resp_err;
  logic [31:0]  rd_word;
  logic [127:0] rd_line;
  logic [31:0]  axi_araddr;
  logic [7:0]   axi_arlen;
  logic [2:0]   axi_arsize;
  logic         axi_arvalid, axi_arready;
  logic [31:0]  axi_rdata;
  logic [1:0]   axi_rresp;
  logic         axi_rlast, axi_rvalid, axi_rready;

  always #5 clk = ~clk;

  read_axi_buffer #(.LINE_SIZE(LINE_SIZE)) dut (
    .clk(clk), .rst(rst), .en(en), .uncached(uncached), .addr(addr), .size(size),
    .empty(empty), .done(done), .rd_word(rd_word), .rd_line(rd_line), .resp_err(resp_err),
    .axi_araddr(axi_araddr), .axi_arlen(axi_arlen), .axi_arsize(axi_arsize),
    .axi_arvalid(axi_arvalid), .axi_arready(axi_arready),
    .axi_rdata(axi_rdata), .axi_rresp(axi_rresp), .axi_rlast(axi_rlast),
    .axi_rvalid(axi_rvalid), .axi_rready(axi_rready)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: request -> address phase -> data phase -> one done cycle.
  bit           m_ar, m_r, m_done, m_err;
  logic [31:0]  m_addr, m_word;
  logic [7:0]   m_arlen;
  logic [2:0]   m_size;
  logic [127:0] m_line;
  int           m_cnt;
  int           done_pulses = 0;

  always @(negedge clk) begin
    if (rst) begin
      m_ar = 1'b0; m_r = 1'b0; m_done = 1'b0; m_err = 1'b0;
      m_word = '0; m_line = '0;
    end
    chk("empty", 128'(empty), 128'(!(m_ar || m_r || m_done)));
    chk("done", 128'(done), 128'(m_done));
    chk("ar_valid", 128'(axi_arvalid), 128'(m_ar));
    chk("ar_payload", 128'({axi_araddr, axi_arlen, axi_arsize}),
        m_ar ? 128'({m_addr, m_arlen, m_size}) : 128'(0));
    chk("r_ready", 128'(axi_rready), 128'(m_r));
    chk("rd_word", 128'(rd_word), 128'(m_word));
    chk("rd_line", rd_line, m_line);
    chk("resp_err", 128'(resp_err), 128'(m_err));
    if (done) done_pulses++;
    if (!rst) begin
      if (m_done) begin
        m_done = 1'b0;
      end else if (!m_ar && !m_r) begin
        if (en) begin
          m_ar = 1'b1; m_addr = addr; m_size = size;
          m_arlen = uncached ? 8'd0 : 8'(BEATS - 1);
          m_word = '0; m_line = '0; m_err = 1'b0; m_cnt = 0;
        end
      end else if (m_ar) begin
        if (axi_arready) begin m_ar = 1'b0; m_r = 1'b1; end
      end else if (axi_rvalid) begin
        if (m_cnt < int'(BEATS)) begin
          m_line[32*m_cnt +: 32] = axi_rdata;
          if (m_cnt == 0) m_word = axi_rdata;
        end
        m_cnt++;
        if (ERR_ON && axi_rresp[1]) m_err = 1'b1;
        if (axi_rlast) begin m_r = 1'b0; m_done = 1'b1; end
      end
    end
  end

  // All stimulus tasks start and end just after a rising edge.
  task automatic start_req(input logic unc, input logic [31:0] a, input logic [2:0] s);
    en = 1'b1; uncached = unc; addr = a; size = s;
    @(posedge clk); #1 en = 1'b0;
  endtask

  task automatic ar_grant(input int stall, input logic [31:0] ea, input logic [7:0] el);
    bit ok;
    for (int i = 0; i < stall; i++) begin
      @(negedge clk);
      chk("bp_arvalid", 128'(axi_arvalid), 128'(1));
      chk("bp_rready", 128'(axi_rready), 128'(0));
      chk("bp_payload", 128'({axi_araddr, axi_arlen}), 128'({ea, el}));
      @(posedge clk); #1;
    end
    axi_arready = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (axi_arvalid) begin ok = 1'b1; break; end
      @(posedge clk); #1;
    end
    chk("ar_handshake", 128'(ok), 128'(1));
    chk("ar_payload_lit", 128'({axi_araddr, axi_arlen}), 128'({ea, el}));
    @(posedge clk); #1 axi_arready = 1'b0;
  endtask

  task automatic send_beat(input logic [31:0] d, input logic [1:0] r, input logic l, input int gap);
    bit ok;
    repeat (gap) begin @(posedge clk); #1; end
    axi_rvalid = 1'b1; axi_rdata = d; axi_rresp = r; axi_rlast = l;
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (axi_rready) begin ok = 1'b1; break; end
      @(posedge clk); #1;
    end
    chk("r_handshake", 128'(ok), 128'(1));
    @(posedge clk); #1;
    axi_rvalid = 1'b0; axi_rlast = 1'b0; axi_rresp = 2'b00;
  endtask

  task automatic wait_done(input string name);
    int cyc;
    cyc = 0;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (done) begin cyc = i; break; end
      @(posedge clk); #1;
    end
    chk(name, 128'(cyc), 128'(1));
    @(posedge clk); #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int lat;
    int p0;
    en = 1'b0; uncached = 1'b0; addr = '0; size = '0;
    axi_arready = 1'b0; axi_rdata = '0; axi_rresp = 2'b00; axi_rlast = 1'b0; axi_rvalid = 1'b0;
    #1 rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    @(negedge clk);
    chk("rst_empty", 128'(empty), 128'(1));
    chk("rst_done", 128'(done), 128'(0));
    chk("rst_line", rd_line, 128'(0));
    chk("rst_arvalid", 128'(axi_arvalid), 128'(0));
    @(posedge clk); #1;

    // Uncached single beat with everything ready: done visible on the third cycle.
    en = 1'b1; uncached = 1'b1; addr = 32'h1000_0004; size = 3'd2;
    axi_arready = 1'b1; axi_rvalid = 1'b1; axi_rdata = 32'hDEAD_BEEF; axi_rlast = 1'b1;
    @(posedge clk); #1 en = 1'b0;
    lat = 0;
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk);
      if (i == 1) begin
        chk("unc_arlen", 128'(axi_arlen), 128'(0));
        chk("unc_araddr", 128'(axi_araddr), 128'(32'h1000_0004));
        chk("unc_arsize", 128'(axi_arsize), 128'(2));
      end
      if (done) begin lat = i; break; end
      @(posedge clk); #1;
    end
    chk("unc_latency", 128'(lat), 128'(3));
    chk("unc_rd_word", 128'(rd_word), 128'(32'hDEAD_BEEF));
    @(posedge clk); #1;
    axi_arready = 1'b0; axi_rvalid = 1'b0; axi_rlast = 1'b0;

    // Line refill with gaps between beats.
    start_req(1'b0, 32'h2000_0000, 3'd2);
    ar_grant(0, 32'h2000_0000, 8'd3);
    p0 = done_pulses;
    send_beat(32'h11, 2'b00, 1'b0, 0);
    send_beat(32'h22, 2'b00, 1'b0, 2);
    send_beat(32'h33, 2'b00, 1'b0, 1);
    send_beat(32'h44, 2'b00, 1'b1, 3);
    wait_done("refill_done");
    chk("refill_line", rd_line, 128'h00000044_00000033_00000022_00000011);
    repeat (3) begin @(posedge clk); #1; end
    chk("refill_pulses", 128'(done_pulses - p0), 128'(1));
    chk("refill_hold", rd_line, 128'h00000044_00000033_00000022_00000011);
    chk("refill_word", 128'(rd_word), 128'(32'h11));

    // Address channel backpressure.
    start_req(1'b0, 32'h3000_0040, 3'd2);
    ar_grant(5, 32'h3000_0040, 8'd3);
    send_beat(32'hA1, 2'b00, 1'b0, 0);
    send_beat(32'hA2, 2'b00, 1'b0, 0);
    send_beat(32'hA3, 2'b00, 1'b0, 0);
    send_beat(32'hA4, 2'b00, 1'b1, 0);
    wait_done("bp_done");
    chk("bp_line", rd_line, 128'h000000A4_000000A3_000000A2_000000A1);

    // Early rlast on beat 2, with a request strobe during the data phase.
    start_req(1'b0, 32'h4000_0000, 3'd2);
    ar_grant(0, 32'h4000_0000, 8'd3);
    send_beat(32'hAA, 2'b00, 1'b0, 0);
    en = 1'b1; addr = 32'h5555_0000;
    send_beat(32'hBB, 2'b00, 1'b1, 1);
    en = 1'b0;
    wait_done("early_done");
    chk("early_line", rd_line, 128'h00000000_00000000_000000BB_000000AA);
    @(negedge clk);
    chk("early_no_req", 128'({empty, axi_arvalid}), 128'(2'b10));
    @(posedge clk); #1;

    // Overrun: six beats into a four-slot line.
    start_req(1'b0, 32'h4800_0000, 3'd2);
    ar_grant(0, 32'h4800_0000, 8'd3);
    for (int k = 1; k <= 6; k++) send_beat(32'(k), 2'b00, 1'(k == 6), 0);
    wait_done("sat_done");
    chk("sat_line", rd_line, 128'h00000004_00000003_00000002_00000001);

    // Reset after the first beat of a refill; later beats must be ignored.
    start_req(1'b0, 32'h6000_0000, 3'd2);
    ar_grant(0, 32'h6000_0000, 8'd3);
    send_beat(32'hC1, 2'b00, 1'b0, 0);
    rst = 1'b1;
    axi_rvalid = 1'b1; axi_rdata = 32'hC2;
    @(negedge clk);
    chk("midrst_state", 128'({empty, done, axi_rready, axi_arvalid}), 128'(4'b1000));
    chk("midrst_word", 128'(rd_word), 128'(0));
    chk("midrst_line", rd_line, 128'(0));
    @(posedge clk); #1 rst = 1'b0;
    axi_rdata = 32'hC3; axi_rlast = 1'b1;
    repeat (3) begin @(posedge clk); #1; end
    @(negedge clk);
    chk("postrst_word", 128'(rd_word), 128'(0));
    chk("postrst_empty", 128'(empty), 128'(1));
    @(posedge clk); #1;
    axi_rvalid = 1'b0; axi_rlast = 1'b0;

    // Error response on beat 3, cleared by the next request.
    start_req(1'b0, 32'h7000_0000, 3'd2);
    ar_grant(0, 32'h7000_0000, 8'd3);
    send_beat(32'h71, 2'b00, 1'b0, 0);
    send_beat(32'h72, 2'b00, 1'b0, 0);
    send_beat(32'h73, 2'b10, 1'b0, 0);
    send_beat(32'h74, 2'b00, 1'b1, 0);
    wait_done("err_done");
    chk("err_sticky", 128'(resp_err), 128'(ERR_ON));
    start_req(1'b1, 32'h7000_0100, 3'd2);
    @(negedge clk);
    chk("err_cleared", 128'(resp_err), 128'(0));
    @(posedge clk); #1;
    ar_grant(0, 32'h7000_0100, 8'd0);
    send_beat(32'h99, 2'b00, 1'b1, 0);
    wait_done("unc2_done");
    chk("unc2_word", 128'(rd_word), 128'(32'h99));
    chk("unc2_line", rd_line, 128'h00000000_00000000_00000000_00000099);

    repeat (3) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/read_axi_buffer.md
READ_AXI_BUFFER -- requirements
Module: read_axi_buffer

Interface
REQ-001 SHALL have parameter LINE_SIZE, default 16, meaning cache line bytes (multiple of 4, range 4..64).
REQ-002 SHALL have ports:
- clk  in  1  sole clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- en  in  1  request strobe.
- uncached  in  1  1 = single-beat read, 0 = line refill.
- addr  in  32  start address.
- size  in  3  AXI size code.
- empty  out  1  1 = IDLE, request accepted.
- done  out  1  one-cycle completion pulse.
- rd_word  out  32  uncached result / first beat.
- rd_line  out  LINE_SIZE*8  refilled line, beat k at bits [32k+31:32k].
- resp_err  out  1  sticky-per-request error flag.
- axi_araddr/axi_arlen/axi_arsize  out  32/8/3  AR payload.
- axi_arvalid  out  1; axi_arready  in  1.
- axi_rdata  in  32; axi_rresp  in  2; axi_rlast  in  1; axi_rvalid  in  1; axi_rready  out  1.

Function
REQ-003 SHALL implement states IDLE, WAIT_ADDR, WAIT_DATA, DONE.
REQ-004 SHALL, in IDLE with en=1, latch uncached/addr/size, zero rd_line, rd_word, beat counter, resp_err, and enter WAIT_ADDR next cycle; en outside IDLE SHALL be ignored.
REQ-005 SHALL hold axi_arvalid=1 with stable payload throughout WAIT_ADDR: araddr=latched addr, arlen=0 if uncached else LINE_SIZE/4-1, arsize=latched size; all AR outputs 0 elsewhere.
REQ-006 SHALL leave WAIT_ADDR for WAIT_DATA on the cycle axi_arvalid&axi_arready.
REQ-007 SHALL drive axi_rready=1 only in WAIT_DATA.
REQ-008 SHALL, per R beat (rvalid&rready), write axi_rdata into rd_line slot counter and increment counter; slot 0 beat also loads rd_word.
REQ-009 SHALL saturate counter at LINE_SIZE/4-1; beats beyond that SHALL be discarded but still accepted.
REQ-010 SHALL enter DONE after the beat carrying axi_rlast=1; early rlast SHALL leave unfilled slots zero.
REQ-011 SHALL assert done=1 for exactly the single DONE cycle, then return to IDLE; rd_word/rd_line SHALL hold until next accepted request.
REQ-012 empty SHALL equal (state==IDLE); minimum request-to-done latency SHALL be 3 cycles for uncached with ready/valid immediately high.

Reset
REQ-013 SHALL, on rst asserted (asynchronous), force IDLE, counter 0, rd_word 0, rd_line 0, resp_err 0, done 0, all AXI outputs 0; empty=1.
REQ-014 SHALL, on rst mid-transaction, abandon the burst without draining; post-reset R beats SHALL be ignored.

Configuration
REQ-015 Macro READ_AXI_RRESP_CHECK_EN: when defined, resp_err SHALL set on any beat with axi_rresp[1]=1 (SLVERR/DECERR) and hold until next accepted request; when undefined, axi_rresp SHALL be ignored and resp_err tied 0.

Structure
REQ-016 Shared package SHALL hold state encoding constants and AXI burst/resp constants (RESP_OKAY=0, RESP_SLVERR=2, RESP_DECERR=3).
REQ-017 No sub-module; single flat module.

Verification
REQ-018 Uncached: en, addr=0x1000_0004, size=2; arready=1; one beat rdata=0xDEADBEEF, rlast=1 -> arlen=0, done on 3rd cycle, rd_word=0xDEADBEEF.
REQ-019 Cached refill LINE_SIZE=16: beats 0x11,0x22,0x33,0x44 (rlast on 4th), rvalid gaps between beats -> arlen=3, rd_line=0x00000044_00000033_00000022_00000011, single done pulse.
REQ-020 AR backpressure: arready low 5 cycles -> arvalid and payload stable all 5 cycles, no rready before handshake.
REQ-021 Early rlast on beat 2 of 4 -> done, rd_line slots 2..3 zero; en during WAIT_DATA ignored.
REQ-022 Reset mid-burst after beat 1 -> immediate IDLE, outputs zero; with macro defined, rresp=2 on beat 3 -> resp_err=1 at done, cleared on next en.
